// File: rtl/alu_cmd_sequencer.sv
// Command front-end for ALU_16bit: buffers commands, issues them into the ALU's
// two-register pipeline with carry chaining, and collects results in order.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_cin,
    input  logic             cmd_chain,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_en,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_cin,
    input  logic [15:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    localparam int CPW   = $clog2(CMD_DEPTH);
    localparam int RPW   = $clog2(RSP_DEPTH);
    localparam int CMD_W = 38 + TAG_W;
    localparam int RSP_W = 20 + TAG_W;

    logic [CMD_W-1:0] cmd_mem_r [CMD_DEPTH];
    logic [CPW-1:0]   cmd_wr_r;
    logic [CPW-1:0]   cmd_rd_r;
    logic [CPW:0]     cmd_cnt_r;
    logic [RSP_W-1:0] rsp_mem_r [RSP_DEPTH];
    logic [RPW-1:0]   rsp_wr_r;
    logic [RPW-1:0]   rsp_rd_r;
    logic [RPW:0]     rsp_cnt_r;

    logic             v1_r, v2_r, carry_q_r;
    logic [TAG_W-1:0] tag1_r, tag2_r;
    logic [15:0]      hold_a_r, hold_b_r;
    logic [3:0]       hold_op_r;
    logic             hold_cin_r;

    logic [CMD_W-1:0] head_s;
    logic [RSP_W-1:0] rsp_head_s;
    logic [RPW+1:0]   credit_s;
    logic             cmd_empty_s, cmd_full_s, rsp_empty_s;
    logic             cmd_push_s, issue_s, rsp_pop_s, cin_s;

    assign head_s      = cmd_mem_r[cmd_rd_r];
    assign rsp_head_s  = rsp_mem_r[rsp_rd_r];
    assign cmd_empty_s = (cmd_cnt_r == (CPW+1)'(0));
    assign cmd_full_s  = (cmd_cnt_r == (CPW+1)'(CMD_DEPTH));
    assign rsp_empty_s = (rsp_cnt_r == (RPW+1)'(0));
    // Slots already promised to in-flight commands count against the response FIFO.
    assign credit_s    = (RPW+2)'(rsp_cnt_r) + (RPW+2)'(v1_r) + (RPW+2)'(v2_r);
    assign issue_s     = !RST && !cmd_empty_s && (credit_s < (RPW+2)'(RSP_DEPTH))
                         && !(head_s[37] && v1_r);
    assign cin_s       = head_s[37] ? (v2_r ? alu_carry : carry_q_r) : head_s[36];

    assign cmd_ready   = !RST && !cmd_full_s;
    assign cmd_push_s  = cmd_valid && cmd_ready;
    assign rsp_valid   = !RST && !rsp_empty_s;
    assign rsp_pop_s   = rsp_valid && rsp_ready;
    assign busy        = !RST && (!cmd_empty_s || v1_r || v2_r || !rsp_empty_s);

    // ALU drive: head fields while issuing, otherwise the last issued values
    always_comb begin
        alu_en     = 1'b0;
        alu_a      = 16'h0000;
        alu_b      = 16'h0000;
        alu_opcode = 4'h0;
        alu_cin    = 1'b0;
        if (RST) begin
            alu_en = 1'b0;
        end else if (issue_s) begin
            alu_en     = 1'b1;
            alu_a      = head_s[15:0];
            alu_b      = head_s[31:16];
            alu_opcode = head_s[35:32];
            alu_cin    = cin_s;
        end else begin
            alu_a      = hold_a_r;
            alu_b      = hold_b_r;
            alu_opcode = hold_op_r;
            alu_cin    = hold_cin_r;
        end
    end

    // Response outputs read as zero while the FIFO is empty
    always_comb begin
        rsp_result = 16'h0000;
        rsp_flags  = 4'h0;
        rsp_tag    = '0;
        if (rsp_valid) begin
            rsp_result = rsp_head_s[15:0];
            rsp_flags  = rsp_head_s[19:16];
            rsp_tag    = rsp_head_s[20 +: TAG_W];
        end else begin
            rsp_result = 16'h0000;
        end
    end

    // Command FIFO storage
    always_ff @(posedge CLK) begin
        if (cmd_push_s) begin
            cmd_mem_r[cmd_wr_r] <= {cmd_tag, cmd_chain, cmd_cin, cmd_op, cmd_b, cmd_a};
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_wr_r  <= '0;
            cmd_rd_r  <= '0;
            cmd_cnt_r <= '0;
        end else begin
            if (cmd_push_s) cmd_wr_r <= cmd_wr_r + CPW'(1);
            if (issue_s)    cmd_rd_r <= cmd_rd_r + CPW'(1);
            cmd_cnt_r <= cmd_cnt_r + (CPW+1)'(cmd_push_s) - (CPW+1)'(issue_s);
        end
    end

    // ALU pipeline tracking, tag alignment, carry capture and held drive values
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            tag1_r     <= '0;
            tag2_r     <= '0;
            carry_q_r  <= 1'b0;
            hold_a_r   <= 16'h0000;
            hold_b_r   <= 16'h0000;
            hold_op_r  <= 4'h0;
            hold_cin_r <= 1'b0;
        end else begin
            v1_r   <= issue_s;
            v2_r   <= v1_r;
            tag2_r <= tag1_r;
            if (issue_s) begin
                tag1_r     <= head_s[38 +: TAG_W];
                hold_a_r   <= head_s[15:0];
                hold_b_r   <= head_s[31:16];
                hold_op_r  <= head_s[35:32];
                hold_cin_r <= cin_s;
            end
            if (v2_r) carry_q_r <= alu_carry;
        end
    end

    // Response FIFO storage
    always_ff @(posedge CLK) begin
        if (v2_r && !RST) begin
            rsp_mem_r[rsp_wr_r] <= {tag2_r, alu_zero, alu_carry, alu_overflow,
                                    alu_negative, alu_result};
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_wr_r  <= '0;
            rsp_rd_r  <= '0;
            rsp_cnt_r <= '0;
        end else begin
            if (v2_r)      rsp_wr_r <= rsp_wr_r + RPW'(1);
            if (rsp_pop_s) rsp_rd_r <= rsp_rd_r + RPW'(1);
            rsp_cnt_r <= rsp_cnt_r + (RPW+1)'(v2_r) - (RPW+1)'(rsp_pop_s);
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a two-stage ALU_16bit model.
module tb_alu_cmd_sequencer;
    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_AND = 4'h2,
                           OP_OR  = 4'h3, OP_XOR = 4'h4;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        chain;
        logic [3:0]  tag;
        logic [15:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_cin = 1'b0, cmd_chain = 1'b0;
    logic [15:0] cmd_a = 16'h0, cmd_b = 16'h0;
    logic [3:0]  cmd_op = 4'h0, cmd_tag = 4'h0;
    logic        alu_en, alu_cin;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_carry, alu_overflow, alu_negative;
    logic        rsp_valid, rsp_ready = 1'b1, busy;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags, rsp_tag;

    int n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0;
    logic [23:0] exp_q[$];
    int          en_cyc_q[$];
    logic        en_cin_q[$];
    int          rv_cyc_q[$];
    vec_t        tp[8];

    alu_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ALU plant: result {R, Z, C, V, N}
    function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic ci);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_ADC:  s = {1'b0, a} + {1'b0, b} + {16'h0, ci};
            OP_AND:  s = {1'b0, a & b};
            OP_OR:   s = {1'b0, a | b};
            OP_XOR:  s = {1'b0, a ^ b};
            default: s = 17'h0;
        endcase
        r = s[15:0];
        if (op == OP_ADD || op == OP_ADC) begin
            c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
        end
        return {r, (r == 16'h0), c, v, r[15]};
    endfunction

    logic [15:0] ra, rb;
    logic [3:0]  rop;
    logic        rci;
    always @(posedge CLK) begin
        if (RST) begin
            ra <= 16'h0; rb <= 16'h0; rop <= 4'h0; rci <= 1'b0;
            {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} <= 20'h0;
        end else begin
            if (alu_en) begin
                ra <= alu_a; rb <= alu_b; rop <= alu_opcode; rci <= alu_cin;
            end
            {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} <= alu_fn(rop, ra, rb, rci);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: issue log, valid log, and scoreboard pop on every handshake
    always @(negedge CLK) begin
        logic [23:0] e;
        if (alu_en) begin
            en_cyc_q.push_back(cyc);
            en_cin_q.push_back(alu_cin);
        end
        if (rsp_valid) rv_cyc_q.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_tag), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e[23:8]));
                check("rsp_flags",  32'(rsp_flags),  32'(e[7:4]));
                check("rsp_tag",    32'(rsp_tag),    32'(e[3:0]));
            end
        end
    end

    task automatic clear_logs();
        en_cyc_q.delete();
        en_cin_q.delete();
        rv_cyc_q.delete();
    endtask

    // Leaves cmd_valid high so back-to-back pushes stay contiguous
    task automatic push(input vec_t v);
        int n;
        cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_op = v.op;
        cmd_cin = v.cin; cmd_chain = v.chain; cmd_tag = v.tag;
        exp_q.push_back({v.exp_r, v.exp_f, v.tag});
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;
        @(posedge CLK); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge CLK); #1; n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_lost", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int a0, first;
        tp[0] = '{OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0, 4'd0, 16'h0003, 4'b0000};
        tp[1] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd1, 16'h8000, 4'b0011};
        tp[2] = '{OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 4'd2, 16'h00F0, 4'b0000};
        tp[3] = '{OP_OR,  16'h8000, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h8001, 4'b0001};
        tp[4] = '{OP_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 4'd4, 16'h0000, 4'b1000};
        tp[5] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 1'b0, 4'd5, 16'h0000, 4'b1110};
        tp[6] = '{OP_ADC, 16'h1234, 16'h1111, 1'b1, 1'b0, 4'd6, 16'h2346, 4'b0000};
        tp[7] = '{OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'd7, 16'hFFFE, 4'b0101};

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_en",    32'(alu_en),    32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        RST = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_rsp_result", 32'(rsp_result), 32'd0);
        @(posedge CLK); #1;

        // single ADD with wrap to zero
        clear_logs();
        push('{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h0000, 4'b1100});
        cmd_valid = 1'b0;
        drain();
        check("single_en_count", 32'(en_cyc_q.size()), 32'd1);
        check("single_en_cycle", 32'(en_cyc_q[0]), 32'(acc_cyc + 1));
        check("single_rsp_cycle", 32'(rv_cyc_q[0]), 32'(acc_cyc + 4));

        // carry chain, back-to-back
        clear_logs();
        push('{OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd1, 16'h0000, 4'b1100});
        push('{OP_ADC, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd2, 16'h0001, 4'b0000});
        cmd_valid = 1'b0;
        drain();
        check("chain_en_count", 32'(en_cyc_q.size()), 32'd2);
        check("chain_gap", 32'(en_cyc_q[1] - en_cyc_q[0]), 32'd2);
        check("chain_cin0", 32'(en_cin_q[0]), 32'd0);
        check("chain_cin1", 32'(en_cin_q[1]), 32'd1);

        // throughput
        clear_logs();
        for (int i = 0; i < 8; i++) push(tp[i]);
        cmd_valid = 1'b0;
        drain();
        check("tp_en_count", 32'(en_cyc_q.size()), 32'd8);
        check("tp_rv_count", 32'(rv_cyc_q.size()), 32'd8);
        first = en_cyc_q[0];
        for (int i = 1; i < 8; i++) check("tp_en_contig", 32'(en_cyc_q[i]), 32'(first + i));
        for (int i = 0; i < 8; i++) check("tp_rv_contig", 32'(rv_cyc_q[i]), 32'(first + 3 + i));

        // backpressure, then full-FIFO push racing a pop
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = tp[i];
            v.tag = 4'(i + 8);
            push(v);
        end
        cmd_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("bp_en_count", 32'(en_cyc_q.size()), 32'd4);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b1; cmd_a = 16'h0100; cmd_b = 16'h0200; cmd_op = OP_ADD;
        cmd_cin = 1'b0; cmd_chain = 1'b0; cmd_tag = 4'd0;
        exp_q.push_back({16'h0300, 4'b0000, 4'd0});
        rsp_ready = 1'b1;
        a0 = 0;
        while (!alu_en && a0 < 20) begin
            @(posedge CLK); #1; a0++;
        end
        check("full_pop_seen", 32'(alu_en), 32'd1);
        check("full_no_push", 32'(cmd_ready), 32'd0);
        @(posedge CLK); #1;
        check("full_push_next", 32'(cmd_ready), 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        drain();
        check("full_en_total", 32'(en_cyc_q.size()), 32'd9);

        // reset with two responses queued and two in flight
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(tp[i]);
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        check("mid_en_count", 32'(en_cyc_q.size()), 32'd4);
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("mid_post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_post_busy", 32'(busy), 32'd0);
        check("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
        clear_logs();
        rsp_ready = 1'b1;
        push('{OP_ADC, 16'h0005, 16'h0006, 1'b1, 1'b1, 4'd9, 16'h000B, 4'b0000});
        cmd_valid = 1'b0;
        drain();
        check("mid_chain_cin", 32'(en_cin_q[0]), 32'd0);
        check("mid_rv_count", 32'(rv_cyc_q.size()), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command front-end for ALU_16bit.
- Buffers operation commands from a valid/ready producer and issues them to the ALU's EN/A/B/OpCode/Cin inputs, with up to one issue per cycle.
- Tracks the ALU's two-register pipeline and captures Result and flags into an in-order response FIFO.
- Supports carry chaining for multi-word arithmetic: a command's Cin can come from the previous command's Carry.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=4 for full throughput)
TAG_W, 4, width of the opaque command tag, passed through to the response

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command FIFO not full
cmd_a  in  16  operand A
cmd_b  in  16  operand B
cmd_op  in  4  ALU opcode (alu_pkg encoding)
cmd_cin  in  1  explicit carry-in
cmd_chain  in  1  1 = use previous command's Carry as Cin; cmd_cin ignored
cmd_tag  in  TAG_W  opaque tag
alu_en  out  1  to ALU EN
alu_a  out  16  to ALU A
alu_b  out  16  to ALU B
alu_opcode  out  4  to ALU OpCode
alu_cin  out  1  to ALU Cin
alu_result  in  16  from ALU Result
alu_zero  in  1  from ALU Zero flag
alu_carry  in  1  from ALU Carry flag
alu_overflow  in  1  from ALU Overflow flag
alu_negative  in  1  from ALU Negative flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts
rsp_result  out  16  captured Result
rsp_flags  out  4  {Z,C,V,N}
rsp_tag  out  TAG_W  tag of the originating command
busy  out  1  any command queued, in flight, or awaiting pop

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high.
- Reset values:
  - cmd_ready=0 during RST, 1 in the first cycle after RST deasserts.
  - alu_en=0, alu_a/alu_b/alu_opcode/alu_cin=0.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, busy=0.
- Reset clears both FIFOs, in-flight tracking (v1, v2) and carry_q. In-flight results are discarded.
- The integrator drives ALU RST_n = ~RST.
- Command accept: push on cmd_valid & cmd_ready. cmd_ready = !cmd_full, taken from registered state. A pop in the same cycle does not free a slot for a push into a full FIFO.
- In-flight tracking:
  - v1 <= alu_en; v2 <= v1.
  - v1=1: the ALU input registers hold an issued command.
  - v2=1: ALU Result/flags in this cycle belong to the oldest in-flight command.
- ALU latency: alu_en high in cycle t -> ALU outputs valid in cycle t+2. Capture into the response FIFO at the end of t+2. rsp_valid is high no earlier than t+3.
- Capture: when v2=1, push {alu_result, Z, C, V, N, tag} into the response FIFO and set carry_q <= alu_carry. The tag comes from a 2-deep tag shift register aligned with v1/v2.
- Issue condition: cmd FIFO not empty AND (rsp_count + v1 + v2) < RSP_DEPTH AND NOT (head.chain & v1).
  - When true, alu_en=1 and the head is popped in that cycle.
  - The credit check uses registered counts only, so the response FIFO never overflows.
- Carry source for chain=1: alu_cin = v2 ? alu_carry : carry_q (forwarding from the ALU output stage).
  - A chained command directly after its predecessor therefore issues with exactly one bubble cycle.
- Carry source for chain=0: alu_cin = head.cin.
- alu_en=0: alu_a/b/opcode/cin hold their last issued values (no toggling).
- Responses leave in issue order. rsp_* fields are stable while rsp_valid & !rsp_ready.
- busy = !cmd_empty | v1 | v2 | !rsp_empty.
- Full throughput: with rsp_ready=1 and no chain stalls, alu_en stays high every cycle the command FIFO is non-empty.

Test Plan:
- Single op: ADD a=0xFFFF b=0x0001 cin=0 chain=0 tag=3, accepted in cycle 0 -> alu_en high in cycle 1; rsp_valid in cycle 4 with result=0x0000, flags Z=1 C=1 V=0 N=0, tag=3; busy falls after the pop.
- Carry chain: ADC 0xFFFF+0x0001 chain=0 cin=0, then ADC 0x0000+0x0000 chain=1, pushed back-to-back -> alu_en pulses separated by exactly one low cycle; second alu_cin=1; responses 0x0000 (C=1) then 0x0001 (C=0).
- Throughput: 8 independent commands, tags 0..7, rsp_ready=1 -> alu_en high for 8 consecutive cycles; 8 consecutive rsp_valid cycles, first at issue+3; tags in order 0..7.
- Backpressure: rsp_ready=0, push 8 commands -> exactly 4 alu_en pulses; cmd FIFO holds 4; cmd_ready=0. Raise rsp_ready -> all 8 responses, in order, none lost or duplicated.
- Full FIFO: cmd_valid held with FIFO full and a pop in the same cycle -> push not accepted that cycle, accepted the next; no entry overwritten.
- Reset mid-operation: RST for one cycle with v1=v2=1 and 2 responses queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1; a following chain=1 command issues with alu_cin=0.
